// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA modular exponentiation core.
// Holds the FSM state encoding, default widths and the counter-width helper.
package rsa_pkg;

    localparam int RSA_WIDTH   = 32;
    localparam int RSA_E_WIDTH = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REDUCE,
        ST_SQR,
        ST_MUL,
        ST_DONE
    } rsa_state_e;

    // Counter width able to index 0..depth-1, never narrower than one bit.
    function automatic int cnt_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier: p = a*b mod n in exactly WIDTH cycles.
// The first step runs in the start cycle and done marks the final step, whose product is on p.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_cur;
    logic [CW-1:0]    bit_sel;
    logic [WIDTH:0]   r2;
    logic [WIDTH:0]   r3;

    // One MSB-first step; r<n and b<n keep every sum inside WIDTH+1 bits.
    always_comb begin
        r_cur   = start ? '0 : acc;
        bit_sel = start ? CW'(WIDTH - 1) : cnt;
        r2      = {r_cur, 1'b0};
        if (r2 >= {1'b0, n}) r2 = r2 - {1'b0, n};
        r3 = r2;
        if (a[bit_sel]) begin
            r3 = r2 + {1'b0, b};
            if (r3 >= {1'b0, n}) r3 = r3 - {1'b0, n};
        end
    end

    assign p    = r3[WIDTH-1:0];
    assign done = busy && (cnt == '0);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            acc  <= r3[WIDTH-1:0];
            cnt  <= CW'(WIDTH - 2);
            busy <= 1'b1;
        end else if (busy) begin
            acc <= r3[WIDTH-1:0];
            cnt <= cnt - 1'b1;
            if (cnt == '0) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/rsa_modexp_core.sv
// RSA engine: cipht = plaint^e_key mod n_key, left-to-right square-and-multiply on one shared multiplier.
// Define RSA_CONST_TIME_EN to run MUL on every exponent bit and discard it for zero bits.
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH   = RSA_WIDTH,
    parameter int E_WIDTH = RSA_E_WIDTH
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [WIDTH-1:0]   plaint,
    input  logic               in_vaild,
    input  logic [E_WIDTH-1:0] e_key,
    input  logic [WIDTH-1:0]   n_key,
    output logic               ready,
    output logic               vaild,
    output logic [WIDTH-1:0]   cipht,
    output logic               err
);

    localparam int BW = cnt_width(E_WIDTH);

    rsa_state_e         state, state_nxt;
    logic [E_WIDTH-1:0] e_q;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   base;
    logic [WIDTH-1:0]   result;
    logic [BW-1:0]      bit_idx;
    logic               mul_needed;
    logic               bit_set;
    logic               last_bit;
    logic               n_bad;
    logic               mm_op;
    logic               mm_start;
    logic               mm_busy;
    logic               mm_done;
    logic [WIDTH-1:0]   mm_a;
    logic [WIDTH-1:0]   mm_b;
    logic [WIDTH-1:0]   mm_p;

    assign bit_set  = e_q[bit_idx];
    assign last_bit = (bit_idx == '0);
    assign n_bad    = (n_q < WIDTH'(2));

`ifdef RSA_CONST_TIME_EN
    assign mul_needed = 1'b1;
`else
    assign mul_needed = bit_set;
`endif

    assign mm_op    = (state == ST_REDUCE) || (state == ST_SQR) || (state == ST_MUL);
    assign mm_start = mm_op && !mm_busy;
    assign mm_a     = (state == ST_REDUCE) ? base : result;
    assign mm_b     = (state == ST_REDUCE) ? WIDTH'(1) :
                      (state == ST_SQR)    ? result : base;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .hclk    (hclk),
        .hresetn (hresetn),
        .start   (mm_start),
        .a       (mm_a),
        .b       (mm_b),
        .n       (n_q),
        .busy    (mm_busy),
        .done    (mm_done),
        .p       (mm_p)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (in_vaild) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = n_bad ? ST_DONE : ST_REDUCE;
            ST_REDUCE: if (mm_done) state_nxt = ST_SQR;
            ST_SQR:    if (mm_done) state_nxt = mul_needed ? ST_MUL :
                                                last_bit   ? ST_DONE : ST_SQR;
            ST_MUL:    if (mm_done) state_nxt = last_bit ? ST_DONE : ST_SQR;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE);
        vaild = (state == ST_DONE);
    end

    // cipht is written on the step that enters DONE so it is stable for the whole vaild cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            e_q     <= '0;
            n_q     <= '0;
            base    <= '0;
            result  <= '0;
            bit_idx <= '0;
            cipht   <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_vaild) begin
                    e_q <= e_key;
                    n_q <= n_key;
                    err <= 1'b0;
                end
                ST_LOAD: begin
                    base    <= plaint;
                    result  <= WIDTH'(1);
                    bit_idx <= BW'(E_WIDTH - 1);
                    if (n_bad) begin
                        err   <= 1'b1;
                        cipht <= '0;
                    end
                end
                ST_REDUCE: if (mm_done) base <= mm_p;
                ST_SQR: if (mm_done) begin
                    result <= mm_p;
                    if (!mul_needed) begin
                        bit_idx <= bit_idx - 1'b1;
                        if (last_bit) cipht <= mm_p;
                    end
                end
                ST_MUL: if (mm_done) begin
                    if (bit_set) result <= mm_p;
                    bit_idx <= bit_idx - 1'b1;
                    if (last_bit) cipht <= bit_set ? mm_p : result;
                end
                default: ;
            endcase
        end
    end

endmodule
